rgmii_rx_deframer: RTL and testbench
====================================

Name: rgmii_rx_deframer

Overview:
- Receive-side counterpart of the RGMII DDR output path: takes per-pin IDDR outputs (rising/falling samples already aligned to clk) and rebuilds GMII bytes.
- Strips preamble/SFD and emits the frame (DA..FCS) as a byte stream with tlast and an error flag.
- Sits between the input-DDR layer and the Ethernet MAC receive logic in the eth-udp stack; 1 Gb/s only, no backpressure.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes after SFD, including FCS.
- MAX_LEN, 1518, maximum legal frame length in bytes after SFD, including FCS.
- STAT_WIDTH, 16, width of saturating statistics counters.

Ports:
- clk  in  1  RGMII receive clock domain, 125 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rxd_q1  in  4  RXD sampled on rising edge; low nibble.
- rxd_q2  in  4  RXD sampled on falling edge; high nibble.
- rx_ctl_q1  in  1  RX_CTL rising sample, which is RX_DV.
- rx_ctl_q2  in  1  RX_CTL falling sample, which is RX_DV xor RX_ER.
- gmii_rxd  out  8  registered reconstructed byte {q2,q1}.
- gmii_rx_dv  out  1  registered RX_DV.
- gmii_rx_er  out  1  registered RX_ER = q1 ^ q2 of rx_ctl.
- m_axis_tdata  out  8  frame byte.
- m_axis_tvalid  out  1  byte valid. There is no tready.
- m_axis_tlast  out  1  last byte of frame.
- m_axis_tuser  out  1  bad frame; meaningful only with tlast.
- stat_frames_ok  out  STAT_WIDTH  good frames delivered; saturating.
- stat_frames_bad  out  STAT_WIDTH  frames ended with tuser=1, plus dropped preambles; saturating.

Behaviour:
- Reset: all outputs and state return to 0 asynchronously. The FSM returns to IDLE and the holding register is cleared.
- GMII stage: one register stage. Inputs present at cycle N appear on gmii_* at N+1.
- FSM states: IDLE, PREAMBLE, PAYLOAD, DROP. The FSM is evaluated on the gmii_* stage.
  - IDLE: on dv=1 with byte 0x55, go to PREAMBLE. On dv=1 with 0xD5, go to PAYLOAD (short preamble is accepted). On dv=1 with any other byte, go to DROP.
  - PREAMBLE: 0x55 stays in PREAMBLE. 0xD5 goes to PAYLOAD, clears len and err. Any other byte, or rx_er=1, goes to DROP. dv=0 goes to IDLE and increments stat_frames_bad.
  - PAYLOAD, each dv=1 cycle:
    - Byte enters the holding register.
    - The previous held byte, if any, is driven on m_axis with tvalid=1, tlast=0.
    - len increments (16-bit).
    - rx_er=1 sets err.
  - PAYLOAD, first dv=0 cycle:
    - The held byte is emitted with tlast=1.
    - tuser = err | (len<MIN_LEN) | (len>MAX_LEN).
    - Go to IDLE.
  - PAYLOAD, when len reaches MAX_LEN+1 with dv=1 (the byte is accepted into the holding register): the held byte is emitted with tlast=1, tuser=1, then go to DROP.
  - DROP: ignore everything until dv=0, then go to IDLE. Nothing is emitted. stat_frames_bad increments only if DROP was entered from IDLE or PREAMBLE; a truncated frame was already counted at its tlast.
- Latency: fixed 3 cycles from input pins to m_axis for every byte, including the last byte (a dv=0 input at N+1 produces tlast at N+3).
- A zero-byte payload (SFD immediately followed by dv=0) emits nothing; stat_frames_bad increments.
- A one-byte payload emits a single beat with tlast=1, tuser=1.
- Back-to-back frames with a 1-cycle dv gap are handled; the IDLE to PREAMBLE decision is taken on the first dv=1 byte.
- Outputs are valid for exactly one cycle; tvalid deasserts between bytes only on gaps.
- Statistics: stat_frames_ok increments at tlast with tuser=0; stat_frames_bad increments at tlast with tuser=1. Both hold at all-ones.
- Carrier extension and false carrier (dv=0, er=1) are ignored in all states.
- Reset mid-frame: no tlast is emitted; counting resumes cleanly after release.

Decomposition:
- Shared package eth_rx_pkg: FSM state enum, ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, default MIN_LEN/MAX_LEN.
- One natural sub-module: sat_counter (parameterised width, inc, synchronous saturate), instantiated twice.

Test Plan:
- 7x0x55 + 0xD5 + 64 bytes 0x00..0x3F, then dv=0 -> 64 beats, data matches, tlast on 0x3F, tuser=0, stat_frames_ok=1, latency 3 cycles.
- Same frame with rx_er=1 on payload byte 10 -> 64 beats, tuser=1 at tlast, stat_frames_bad=1.
- 60-byte frame -> tlast on beat 60, tuser=1; a 1-byte frame -> single beat, tlast=1, tuser=1.
- 1600-byte frame -> tlast on beat 1518, tuser=1, no further beats until dv drops, stat_frames_bad=1.
- Preamble 0x55,0x55,0xAA,... -> no beats, stat_frames_bad=1. Two 64-byte frames separated by 1 idle cycle -> both delivered, stat_frames_ok=2.
- rst_n asserted at payload byte 30 of a 100-byte frame, released, then a clean 64-byte frame -> no tlast for the first frame; the second frame is correct; counters read 0 then 1 ok.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet receive path: framing constants,
// default frame length limits and the deframer FSM state type.
package eth_rx_pkg;

  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD      = 8'hD5;

  localparam int unsigned DEF_MIN_LEN = 64;
  localparam int unsigned DEF_MAX_LEN = 1518;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StPayload,
    StDrop
  } rx_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Increment on request unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rgmii_rx_deframer.sv
// RGMII receive deframer: rebuilds GMII bytes from IDDR samples, strips
// preamble/SFD and streams DA..FCS with tlast/tuser, plus frame statistics.
// Every byte leaves m_axis three cycles after it was on the pins: one cycle in
// the GMII register, one in the holding register, one in the output register.
// The holding register delays emission by one byte so tlast can be attached
// to the final byte when dv drops.
module rgmii_rx_deframer
  import eth_rx_pkg::*;
#(
  parameter int unsigned MIN_LEN    = DEF_MIN_LEN,
  parameter int unsigned MAX_LEN    = DEF_MAX_LEN,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            rxd_q1,
  input  logic [3:0]            rxd_q2,
  input  logic                  rx_ctl_q1,
  input  logic                  rx_ctl_q2,
  output logic [7:0]            gmii_rxd,
  output logic                  gmii_rx_dv,
  output logic                  gmii_rx_er,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [STAT_WIDTH-1:0] stat_frames_ok,
  output logic [STAT_WIDTH-1:0] stat_frames_bad
);

  localparam logic [15:0] MinLen = 16'(MIN_LEN);
  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  logic [7:0] gmii_rxd_q;
  logic       gmii_dv_q, gmii_er_q;

  rx_state_e  state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic [15:0] len_q, len_d;
  logic       err_q, err_d;

  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       tlast_q, tlast_d;
  logic       tuser_q, tuser_d;

  logic       ok_inc, bad_inc;
  logic       frame_bad;

  // GMII reconstruction: falling-edge sample carries the high nibble,
  // RX_ER is recovered as the xor of the two RX_CTL samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gmii_rxd_q <= '0;
      gmii_dv_q  <= 1'b0;
      gmii_er_q  <= 1'b0;
    end else begin
      gmii_rxd_q <= {rxd_q2, rxd_q1};
      gmii_dv_q  <= rx_ctl_q1;
      gmii_er_q  <= rx_ctl_q1 ^ rx_ctl_q2;
    end
  end

  assign frame_bad = err_q | (len_q < MinLen) | (len_q > MaxLen);

  // Deframer next-state, holding register and output beat decode.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    len_d      = len_q;
    err_d      = err_q;
    tdata_d    = '0;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;
    ok_inc     = 1'b0;
    bad_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // rx_er is ignored here; only the first dv byte decides.
        if (gmii_dv_q) begin
          if (gmii_rxd_q == ETH_PREAMBLE) begin
            state_d = StPreamble;
          end else if (gmii_rxd_q == ETH_SFD) begin
            state_d    = StPayload;
            len_d      = '0;
            err_d      = 1'b0;
            hold_vld_d = 1'b0;
          end else begin
            state_d = StDrop;
            bad_inc = 1'b1;
          end
        end
      end

      StPreamble: begin
        if (!gmii_dv_q) begin
          state_d = StIdle;
          bad_inc = 1'b1;
        end else if (gmii_er_q ||
                     ((gmii_rxd_q != ETH_PREAMBLE) && (gmii_rxd_q != ETH_SFD))) begin
          state_d = StDrop;
          bad_inc = 1'b1;
        end else if (gmii_rxd_q == ETH_SFD) begin
          state_d    = StPayload;
          len_d      = '0;
          err_d      = 1'b0;
          hold_vld_d = 1'b0;
        end
      end

      StPayload: begin
        if (gmii_dv_q) begin
          hold_d     = gmii_rxd_q;
          hold_vld_d = 1'b1;
          len_d      = len_q + 16'd1;
          if (gmii_er_q) begin
            err_d = 1'b1;
          end
          if (hold_vld_q) begin
            tdata_d  = hold_q;
            tvalid_d = 1'b1;
          end
          // This byte is number MAX_LEN+1: close the frame as oversize.
          if (len_q == MaxLen) begin
            tlast_d    = 1'b1;
            tuser_d    = 1'b1;
            bad_inc    = 1'b1;
            hold_vld_d = 1'b0;
            state_d    = StDrop;
          end
        end else begin
          state_d    = StIdle;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            tdata_d  = hold_q;
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tuser_d  = frame_bad;
            ok_inc   = ~frame_bad;
            bad_inc  = frame_bad;
          end else begin
            // SFD followed directly by end of carrier.
            bad_inc = 1'b1;
          end
        end
      end

      StDrop: begin
        if (!gmii_dv_q) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // FSM, holding register and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      len_q      <= '0;
      err_q      <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      len_q      <= len_d;
      err_q      <= err_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
    end
  end

  sat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_cnt_ok (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ok_inc),
    .count (stat_frames_ok)
  );

  sat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_cnt_bad (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bad_inc),
    .count (stat_frames_bad)
  );

  assign gmii_rxd      = gmii_rxd_q;
  assign gmii_rx_dv    = gmii_dv_q;
  assign gmii_rx_er    = gmii_er_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
// Bench for rgmii_rx_deframer: directed and random frames, checked every cycle
// against a frame-level model, plus literal expectations per scenario.
module tb_rgmii_rx_deframer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int SW      = 16;
  localparam int MAXC    = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    rxd_q1 = '0, rxd_q2 = '0;
  logic          rx_ctl_q1 = 1'b0, rx_ctl_q2 = 1'b0;
  logic [7:0]    gmii_rxd;
  logic          gmii_rx_dv, gmii_rx_er;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [SW-1:0] stat_frames_ok, stat_frames_bad;

  always #4 clk = ~clk;

  rgmii_rx_deframer #(
    .MIN_LEN    (MIN_LEN),
    .MAX_LEN    (MAX_LEN),
    .STAT_WIDTH (SW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rxd_q1          (rxd_q1),
    .rxd_q2          (rxd_q2),
    .rx_ctl_q1       (rx_ctl_q1),
    .rx_ctl_q2       (rx_ctl_q2),
    .gmii_rxd        (gmii_rxd),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rx_er      (gmii_rx_er),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .stat_frames_ok  (stat_frames_ok),
    .stat_frames_bad (stat_frames_bad)
  );

  int checks = 0;
  int failures = 0;

  // Per-cycle stimulus of the current segment.
  bit         sdv[$];
  bit         ser[$];
  logic [7:0] sd[$];

  // Expected m_axis, indexed by the clock edge after which it is visible.
  bit         ev[MAXC];
  logic [7:0] ed[MAXC];
  bit         el[MAXC];
  bit         eu[MAXC];
  int         exp_ok = 0, exp_bad = 0;

  int  edge_idx = 0, chk_lim = 0;
  bit  chk_en = 0;
  int  obs_beats = 0, obs_last = 0, first_beat = -1;
  int  last_data = 0, last_user = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push(input bit dv, input bit er, input logic [7:0] d);
    sdv.push_back(dv);
    ser.push_back(er);
    sd.push_back(d);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 8'h00);
  endtask

  task automatic add_frame(input int npre, input int len, input int er_at, input bit rnd);
    for (int i = 0; i < npre; i++) push(1'b1, 1'b0, 8'h55);
    push(1'b1, 1'b0, 8'hD5);
    for (int j = 0; j < len; j++) push(1'b1, j == er_at, rnd ? 8'($urandom) : 8'(j));
  endtask

  task automatic put(input int idx, input logic [7:0] d, input bit last, input bit user);
    if (idx < MAXC) begin
      ev[idx] = 1'b1;
      ed[idx] = d;
      el[idx] = last;
      eu[idx] = user;
    end
  endtask

  // Frame-level model: split the stream into dv bursts and decide each one.
  // A payload byte on the pins in cycle c is visible after edge c+2.
  task automatic build_model(input int n);
    int t, s, e, k, p0, len;
    bit term, perr, err;
    for (int i = 0; i < MAXC; i++) begin
      ev[i] = 1'b0; ed[i] = '0; el[i] = 1'b0; eu[i] = 1'b0;
    end
    t = 0;
    while (t < n) begin
      if (!sdv[t]) begin
        t++;
      end else begin
        s = t;
        while (t < n && sdv[t]) t++;
        e = t - 1;
        term = (t < n);
        k = s;
        while (k <= e && sd[k] == 8'h55) k++;
        perr = 1'b0;
        for (int i = s + 1; i <= k && i <= e; i++) if (ser[i]) perr = 1'b1;
        if (k > e) begin
          if (term || perr) exp_bad++;
        end else if (perr || sd[k] != 8'hD5) begin
          exp_bad++;
        end else begin
          p0 = k + 1;
          len = e - k;
          err = 1'b0;
          if (len == 0) begin
            if (term) exp_bad++;
          end else if (len > MAX_LEN) begin
            for (int j = 0; j < MAX_LEN; j++) put(p0 + j + 2, sd[p0 + j], j == MAX_LEN - 1, 1'b1);
            exp_bad++;
          end else begin
            for (int j = 0; j < len; j++) if (ser[p0 + j]) err = 1'b1;
            for (int j = 0; j < len - 1; j++) put(p0 + j + 2, sd[p0 + j], 1'b0, 1'b0);
            if (term) begin
              put(e + 2, sd[e], 1'b1, err || (len < MIN_LEN));
              if (err || (len < MIN_LEN)) exp_bad++;
              else exp_ok++;
            end
          end
        end
      end
    end
  endtask

  // Drive one segment; rst_at >= 0 asserts reset at that cycle and holds it.
  task automatic run_seg(input int rst_at);
    int n;
    logic [7:0] b;
    n = sdv.size();
    build_model(n);
    obs_beats = 0; obs_last = 0; first_beat = -1;
    chk_lim = n;
    chk_en = 1'b1;
    for (int t = 0; t < n; t++) begin
      if (t == rst_at) begin
        chk_lim = t - 1;
        rst_n = 1'b0;
      end
      b = sd[t];
      rxd_q1 = b[3:0];
      rxd_q2 = b[7:4];
      rx_ctl_q1 = sdv[t];
      rx_ctl_q2 = sdv[t] ^ ser[t];
      @(posedge clk);
      edge_idx = t;
      #1;
    end
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    sdv.delete(); ser.delete(); sd.delete();
  endtask

  task automatic stats(input int lit_ok, input int lit_bad);
    chk("stat_ok_model", int'(stat_frames_ok), exp_ok);
    chk("stat_bad_model", int'(stat_frames_bad), exp_bad);
    chk("stat_ok_literal", int'(stat_frames_ok), lit_ok);
    chk("stat_bad_literal", int'(stat_frames_bad), lit_bad);
  endtask

  task automatic add_random(input int nframes);
    int kind, npre, len, er_at, gap;
    for (int f = 0; f < nframes; f++) begin
      kind = $urandom_range(0, 5);
      npre = $urandom_range(0, 7);
      len = (kind == 3) ? $urandom_range(60, 70) : $urandom_range(0, 90);
      er_at = (kind == 2) ? $urandom_range(0, 90) : -1;
      for (int i = 0; i < npre; i++)
        push(1'b1, (kind == 1) && (i == npre - 1), ((kind == 0) && (i == npre - 1)) ? 8'h3C : 8'h55);
      push(1'b1, 1'b0, 8'hD5);
      for (int j = 0; j < len; j++) push(1'b1, j == er_at, 8'($urandom));
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) push(1'b0, $urandom_range(0, 3) == 0, 8'($urandom));
    end
    add_idle(6);
  endtask

  // Every-cycle comparison of GMII stage and stream outputs against the model.
  always @(negedge clk) begin
    if (chk_en && edge_idx < chk_lim) begin
      if (m_axis_tvalid) begin
        obs_beats++;
        if (first_beat < 0) first_beat = edge_idx;
        if (m_axis_tlast) begin
          obs_last++;
          last_data = int'(m_axis_tdata);
          last_user = int'(m_axis_tuser);
        end
      end
      checks++;
      if (gmii_rxd !== sd[edge_idx] || gmii_rx_dv !== sdv[edge_idx] ||
          gmii_rx_er !== ser[edge_idx]) begin
        failures++;
        $display("FAIL gmii edge=%0d got rxd=%h dv=%b er=%b want rxd=%h dv=%b er=%b", edge_idx,
                 gmii_rxd, gmii_rx_dv, gmii_rx_er, sd[edge_idx], sdv[edge_idx], ser[edge_idx]);
      end
      checks++;
      if (m_axis_tvalid !== ev[edge_idx] ||
          (ev[edge_idx] && (m_axis_tdata !== ed[edge_idx] || m_axis_tlast !== el[edge_idx] ||
                            (el[edge_idx] && m_axis_tuser !== eu[edge_idx])))) begin
        failures++;
        $display("FAIL axis edge=%0d got v=%b d=%h l=%b u=%b want v=%b d=%h l=%b u=%b", edge_idx,
                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, ev[edge_idx],
                 ed[edge_idx], el[edge_idx], eu[edge_idx]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tvalid", int'(m_axis_tvalid), 0);
    chk("reset_tlast", int'(m_axis_tlast), 0);
    chk("reset_gmii_dv", int'(gmii_rx_dv), 0);
    stats(0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good 64-byte frame with full preamble.
    add_idle(2); add_frame(7, 64, -1, 1'b0); add_idle(6); run_seg(-1);
    chk("s1_beats", obs_beats, 64);
    chk("s1_tlast", obs_last, 1);
    chk("s1_latency_edge", first_beat, 12);
    chk("s1_last_data", last_data, 'h3F);
    chk("s1_last_user", last_user, 0);
    stats(1, 0);

    // rx_er on payload byte 10.
    add_idle(2); add_frame(7, 64, 10, 1'b0); add_idle(6); run_seg(-1);
    chk("s2_beats", obs_beats, 64);
    chk("s2_last_user", last_user, 1);
    stats(1, 1);

    // Runt frames: 60 bytes, then 1 byte.
    add_idle(2); add_frame(7, 60, -1, 1'b0); add_idle(6); run_seg(-1);
    chk("s3_beats", obs_beats, 60);
    chk("s3_last_user", last_user, 1);
    stats(1, 2);
    add_idle(2); add_frame(7, 1, -1, 1'b0); add_idle(6); run_seg(-1);
    chk("s3b_beats", obs_beats, 1);
    chk("s3b_tlast", obs_last, 1);
    chk("s3b_last_user", last_user, 1);
    stats(1, 3);

    // Oversize frame truncated at MAX_LEN.
    add_idle(2); add_frame(7, 1600, -1, 1'b0); add_idle(6); run_seg(-1);
    chk("s4_beats", obs_beats, 1518);
    chk("s4_tlast", obs_last, 1);
    chk("s4_last_data", last_data, 1517 % 256);
    stats(1, 4);

    // Corrupt preamble.
    add_idle(2); push(1, 0, 8'h55); push(1, 0, 8'h55); push(1, 0, 8'hAA);
    push(1, 0, 8'hD5); push(1, 0, 8'h12); push(1, 0, 8'h34); add_idle(6); run_seg(-1);
    chk("s5_beats", obs_beats, 0);
    stats(1, 5);

    // Back-to-back frames with a one-cycle gap.
    add_idle(2); add_frame(7, 64, -1, 1'b1); add_idle(1); add_frame(7, 64, -1, 1'b1);
    add_idle(6); run_seg(-1);
    chk("s6_beats", obs_beats, 128);
    chk("s6_tlast", obs_last, 2);
    stats(3, 5);

    // Zero-byte payload.
    add_idle(2); add_frame(3, 0, -1, 1'b0); add_idle(6); run_seg(-1);
    chk("s7_beats", obs_beats, 0);
    stats(3, 6);

    // Randomized frames checked against the model only.
    add_idle(2); add_random(12); run_seg(-1);
    chk("rand_stat_ok", int'(stat_frames_ok), exp_ok);
    chk("rand_stat_bad", int'(stat_frames_bad), exp_bad);

    // Reset at payload byte 30 of a 100-byte frame.
    add_idle(2); add_frame(7, 100, -1, 1'b1); add_idle(4); run_seg(2 + 8 + 30);
    chk("s9_tlast_before_reset", obs_last, 0);
    chk("s9_tvalid_in_reset", int'(m_axis_tvalid), 0);
    exp_ok = 0; exp_bad = 0;
    stats(0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    add_idle(2); add_frame(7, 64, -1, 1'b1); add_idle(6); run_seg(-1);
    chk("s9_beats", obs_beats, 64);
    chk("s9_last_user", last_user, 0);
    stats(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
